// File: rtl/ex_branch_resolve_pkg.sv
// Shared types and helpers for the EX-stage branch unit.
package ex_branch_pkg;

  typedef enum logic [2:0] {
    NONE = 3'd0,
    BEQ  = 3'd1,
    BNE  = 3'd2,
    BLEZ = 3'd3,
    BGTZ = 3'd4,
    BLTZ = 3'd5,
    BGEZ = 3'd6,
    JMP  = 3'd7
  } brop_t;

  // Weakly not-taken: one taken outcome flips the prediction.
  localparam logic [1:0] PHT_INIT = 2'b01;

  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == 2'b11) ? v : v + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] v);
    return (v == 2'b00) ? v : v - 2'd1;
  endfunction

endpackage

// File: rtl/ex_branch_resolve_pht.sv
// Pattern history table: 2-bit saturating counters, one comb read, one update port.
module ex_pht
  import ex_branch_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [IDX_W-1:0] i_raddr,
  output logic             o_rtaken,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic             i_taken
);

  localparam int DEPTH = 2 ** IDX_W;

  logic [DEPTH-1:0][1:0] r_pht;

  // Read returns stored state; a same-cycle update is seen only after the edge.
  assign o_rtaken = r_pht[i_raddr][1];

  // Saturating counter update on resolved conditional branches.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pht <= {DEPTH{PHT_INIT}};
    end else if (i_we) begin
      r_pht[i_waddr] <= i_taken ? sat_inc(r_pht[i_waddr]) : sat_dec(r_pht[i_waddr]);
    end
  end

endmodule

// File: rtl/ex_branch_resolve.sv
// EX-stage branch resolution: target/condition, EX/MEM register, mispredict
// detection, PHT ownership and a saturating mispredict counter.
module ex_branch_resolve
  import ex_branch_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int IMM_W     = 16,
  parameter int PHT_IDX_W = 6,
  parameter int CNT_W     = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_addr_pcF,
  output logic              o_predict_takenF,
  input  logic              i_validE,
  input  logic              i_stallE,
  input  logic              i_flushE,
  input  logic [2:0]        i_ctrl_bropE,
  input  logic              i_predict_takenE,
  input  logic [ADDR_W-1:0] i_addr_pcadd4E,
  input  logic [IMM_W-1:0]  i_data_immE,
  input  logic [31:0]       i_data_rsE,
  input  logic [31:0]       i_data_rtE,
  output logic              o_validM,
  output logic              o_takenM,
  output logic [ADDR_W-1:0] o_addr_pcbranchM,
  output logic              o_mispredictM,
  output logic [ADDR_W-1:0] o_addr_redirectM,
  output logic [CNT_W-1:0]  o_cnt_mispredict
);

  brop_t             w_brop;
  logic              w_takenE;
  logic [ADDR_W-1:0] w_offset;
  logic [ADDR_W-1:0] w_targetE;

  logic              r_validM;
  logic              r_takenM;
  logic              r_predM;
  brop_t             r_bropM;
  logic [ADDR_W-1:0] r_pcbranchM;
  logic [ADDR_W-1:0] r_pcadd4M;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_upd;
  logic [ADDR_W-1:0] w_pcM;
  logic              w_unused;

  assign w_brop    = brop_t'(i_ctrl_bropE);
  assign w_offset  = {{(ADDR_W-IMM_W){i_data_immE[IMM_W-1]}}, i_data_immE} << 2;
  assign w_targetE = i_addr_pcadd4E + w_offset;

  // Branch condition on signed 32-bit operands.
  always_comb begin
    w_takenE = 1'b0;
    case (w_brop)
      BEQ:     w_takenE = (i_data_rsE == i_data_rtE);
      BNE:     w_takenE = (i_data_rsE != i_data_rtE);
      BLEZ:    w_takenE = ($signed(i_data_rsE) <= 0);
      BGTZ:    w_takenE = ($signed(i_data_rsE) > 0);
      BLTZ:    w_takenE = i_data_rsE[31];
      BGEZ:    w_takenE = !i_data_rsE[31];
      JMP:     w_takenE = 1'b1;
      default: w_takenE = 1'b0;
    endcase
  end

  // EX/MEM register: flush kills valid only, stall holds everything.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_validM    <= 1'b0;
      r_takenM    <= 1'b0;
      r_predM     <= 1'b0;
      r_bropM     <= NONE;
      r_pcbranchM <= '0;
      r_pcadd4M   <= '0;
    end else if (i_flushE) begin
      r_validM    <= 1'b0;
    end else if (!i_stallE) begin
      r_validM    <= i_validE;
      r_takenM    <= w_takenE;
      r_predM     <= i_predict_takenE;
      r_bropM     <= w_brop;
      r_pcbranchM <= w_targetE;
      r_pcadd4M   <= i_addr_pcadd4E;
    end
  end

  assign o_validM         = r_validM;
  assign o_takenM         = r_takenM;
  assign o_addr_pcbranchM = r_pcbranchM;
  assign o_mispredictM    = r_validM && (r_bropM != NONE) && (r_takenM != r_predM);
  assign o_addr_redirectM = r_takenM ? r_pcbranchM : r_pcadd4M;

  // A conditional branch trains the PHT once, on the edge where it leaves MEM.
  assign w_upd = r_validM && (r_bropM != NONE) && (r_bropM != JMP) && !i_stallE;
  assign w_pcM = r_pcadd4M - ADDR_W'(4);

  // Mispredict counter, saturating at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (w_upd && o_mispredictM && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt_mispredict = r_cnt;

  ex_pht #(.IDX_W(PHT_IDX_W)) u_pht (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_raddr  (i_addr_pcF[PHT_IDX_W+1:2]),
    .o_rtaken (o_predict_takenF),
    .i_we     (w_upd),
    .i_waddr  (w_pcM[PHT_IDX_W+1:2]),
    .i_taken  (r_takenM)
  );

  // Address bits outside the PHT index are intentionally ignored.
  assign w_unused = ^{i_addr_pcF, w_pcM};

endmodule
